seg_scan_ctrl: RTL



---
 rtl/seg_scan_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexing scan controller for a common-anode seven-segment display.
//   Each frame shows every digit in turn: an all-anodes-off guard interval
//   (decoder input already settled), then the digit lit for REFRESH_DIV cycles.
//   Digit values, decimal points and blanking are latched once per frame so that
//   input changes never tear a frame.
//
//   Optional feature: define SEG_SCAN_LZ_BLANK_EN to enable leading-zero
//   suppression at frame latch time (digit 0 is never suppressed).
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   en         in   scan enable; dropping it returns to idle on the next edge
//   digits_in  in   4*NUM_DIGITS, nibble i = digit i (digit 0 rightmost)
//   dp_in      in   per-digit decimal point request, active-high
//   blank_in   in   per-digit force-blank, active-high
//   dec_d      out  nibble to the shared segment decoder
//   an         out  digit anode enables, active-low
//   dp         out  decimal point, active-low
//   digit_idx  out  index of the selected digit
//   frame_done out  one-cycle pulse after the last digit of a frame
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned GUARD_CYCLES = 16,
    parameter int unsigned IDX_W        = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    output logic [3:0]                dec_d,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      dp,
    output logic [IDX_W-1:0]          digit_idx,
    output logic                      frame_done
);

    // Counter counts 0..max-1, so $clog2(max) bits are enough.
    localparam int unsigned CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StGuard, StShow} state_e;

    // First state of every digit slot; the guard is skipped entirely when it is zero.
    localparam state_e SlotStart = (GUARD_CYCLES == 0) ? StShow : StGuard;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   digits_q, digits_d;
    logic [NUM_DIGITS-1:0]     dpf_q, dpf_d;
    logic [NUM_DIGITS-1:0]     blank_q, blank_d;
    logic [3:0]                nib_q, nib_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d;
    logic                      dp_q, dp_d;
    logic                      fd_q, fd_d;
    logic                      latch;
    logic [NUM_DIGITS-1:0]     lz_blank;

`ifdef SEG_SCAN_LZ_BLANK_EN
    // Walk down from the top digit; suppression stops at the first non-zero
    // digit or requested decimal point.
    always_comb begin : lz_calc
        logic run;
        run      = 1'b1;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            run         = run & (digits_in[4*i +: 4] == 4'h0) & ~dp_in[i];
            lz_blank[i] = run;
        end
    end
`else
    assign lz_blank = '0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        digits_d = digits_q;
        dpf_d    = dpf_q;
        blank_d  = blank_q;
        fd_d     = 1'b0;
        latch    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (en) begin
                    latch   = 1'b1;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = SlotStart;
                end
            end
            StGuard: begin
                if (cnt_q == GUARD_LAST) begin
                    cnt_d   = '0;
                    state_d = StShow;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShow: begin
                if (cnt_q == SHOW_LAST) begin
                    cnt_d   = '0;
                    state_d = SlotStart;
                    if (idx_q == LAST_IDX) begin
                        // Completed frame is reported even if en drops on this edge.
                        fd_d  = 1'b1;
                        idx_d = '0;
                        latch = en;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle && !en) begin
            state_d = StIdle;
            cnt_d   = '0;
            idx_d   = '0;
        end

        if (latch) begin
            digits_d = digits_in;
            dpf_d    = dp_in;
            blank_d  = blank_in | lz_blank;
        end

        // Outputs are derived from the next state so the registered pins line up
        // with the registered state.
        an_d  = '1;
        dp_d  = 1'b1;
        nib_d = 4'h0;
        if (state_d != StIdle) begin
            nib_d = digits_d[4*idx_d +: 4];
        end
        if (state_d == StShow && !blank_d[idx_d]) begin
            an_d[idx_d] = 1'b0;
            dp_d        = ~dpf_d[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            digits_q <= '0;
            dpf_q    <= '0;
            blank_q  <= '0;
            nib_q    <= 4'h0;
            an_q     <= '1;
            dp_q     <= 1'b1;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            digits_q <= digits_d;
            dpf_q    <= dpf_d;
            blank_q  <= blank_d;
            nib_q    <= nib_d;
            an_q     <= an_d;
            dp_q     <= dp_d;
            fd_q     <= fd_d;
        end
    end

    assign dec_d      = nib_q;
    assign an         = an_q;
    assign dp         = dp_q;
    assign digit_idx  = idx_q;
    assign frame_done = fd_q;

endmodule
